// File: rtl/shared_adder_arbiter.sv
// rtl/shared_adder_arbiter.sv - round-robin arbiter sharing one signed adder among N_REQ requesters
module shared_adder_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ*WIDTH-1:0]       req_a,
   input  logic [N_REQ*WIDTH-1:0]       req_b,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [WIDTH:0]               res_data,
   output logic [$clog2(N_REQ)-1:0]     res_id,
   output logic [CNT_W-1:0]             op_count
);

   localparam int ID_W = $clog2(N_REQ);

   logic              res_valid_q, res_valid_d;
   logic [WIDTH:0]    res_data_q, res_data_d;
   logic [ID_W-1:0]   res_id_q, res_id_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  op_count_q, op_count_d;

   logic              res_free;
   logic              any_valid;
   logic              accept;
   logic [ID_W-1:0]   grant;
   logic [ID_W-1:0]   idx;
   logic [WIDTH-1:0]  a_sel, b_sel;
   logic [WIDTH:0]    sum;

   assign res_free  = !res_valid_q || res_ready;
   assign any_valid = |req_valid;

   // Cyclic priority search starting at rr_ptr; power-of-two N_REQ lets the index wrap naturally.
   always_comb begin
      grant = rr_ptr_q;
      idx   = rr_ptr_q;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = rr_ptr_q + ID_W'(k);
         if (req_valid[idx]) begin
            grant = idx;
         end
      end
   end

   // One-hot ready to the winner only when the result slot can take a new value; held low in reset.
   always_comb begin
      req_ready = '0;
      if (rst && res_free && any_valid) begin
         req_ready[grant] = 1'b1;
      end
   end

   assign accept = |(req_valid & req_ready);

   assign a_sel = req_a[int'(grant)*WIDTH +: WIDTH];
   assign b_sel = req_b[int'(grant)*WIDTH +: WIDTH];
   assign sum   = {a_sel[WIDTH-1], a_sel} + {b_sel[WIDTH-1], b_sel};

   // Result stage next state: refill on accept (drain and refill may coincide), drain when consumed.
   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      rr_ptr_d    = rr_ptr_q;
      op_count_d  = op_count_q;
      if (accept) begin
         res_valid_d = 1'b1;
         res_data_d  = sum;
         res_id_d    = grant;
         rr_ptr_d    = grant + ID_W'(1);
         if (!(&op_count_q)) begin
            op_count_d = op_count_q + CNT_W'(1);
         end
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   // State registers; reset drops any held result without presenting it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= '0;
         rr_ptr_q    <= '0;
         op_count_q  <= '0;
      end else begin
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
         rr_ptr_q    <= rr_ptr_d;
         op_count_q  <= op_count_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// tb/tb_shared_adder_arbiter.sv - directed self-checking bench for shared_adder_arbiter
module tb_shared_adder_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready, req_ready_s;
   logic [7:0]  req_a, req_b;
   logic        res_valid, res_valid_s;
   logic        res_ready;
   logic [2:0]  res_data, res_data_s;
   logic [1:0]  res_id, res_id_s;
   logic [15:0] op_count;
   logic [3:0]  op_count_s;

   int tests;
   int errors;
   logic [2:0] rr_exp [4];

   shared_adder_arbiter #(.N_REQ(4), .WIDTH(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .op_count(op_count)
   );

   shared_adder_arbiter #(.N_REQ(4), .WIDTH(2), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
      .req_a(req_a), .req_b(req_b), .res_valid(res_valid_s), .res_ready(res_ready),
      .res_data(res_data_s), .res_id(res_id_s), .op_count(op_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_res(input string tag, input logic v, input logic [2:0] d,
                          input logic [1:0] id, input logic [15:0] cnt);
      chk({tag, "_valid"}, 32'(res_valid), 32'(v));
      chk({tag, "_data"},  32'(res_data),  32'(d));
      chk({tag, "_id"},    32'(res_id),    32'(id));
      chk({tag, "_count"}, 32'(op_count),  32'(cnt));
   endtask

   initial begin
      tests = 0;
      errors = 0;
      rst = 1'b0;
      req_valid = 4'b1111;
      req_a = '0;
      req_b = '0;
      res_ready = 1'b1;
      #1;
      // reset state, ready gated even with requests pending
      chk_res("reset", 1'b0, 3'd0, 2'd0, 16'd0);
      chk("reset_ready", 32'(req_ready), 32'h0);
      step();
      step();
      req_valid = 4'b0000;
      rst = 1'b1;
      step();
      step();
      chk_res("idle", 1'b0, 3'd0, 2'd0, 16'd0);
      chk("idle_ready", 32'(req_ready), 32'h0);

      // single request from requester 2: 1 + 1 = 2
      req_valid = 4'b0100;
      req_a[5:4] = 2'b01;
      req_b[5:4] = 2'b01;
      #1;
      chk("single_ready", 32'(req_ready), 32'h4);
      step();
      req_valid = 4'b0000;
      #1;
      chk_res("single", 1'b1, 3'b010, 2'd2, 16'd1);

      // requester 0: -2 + -2 = -4; rr_ptr=3 wraps to 0
      req_valid = 4'b0001;
      req_a[1:0] = 2'b10;
      req_b[1:0] = 2'b10;
      #1;
      chk("neg_ready", 32'(req_ready), 32'h1);
      step();
      // requester 1: 1 + -2 = -1, issued back-to-back
      req_valid = 4'b0010;
      req_a[3:2] = 2'b01;
      req_b[3:2] = 2'b10;
      #1;
      chk_res("neg4", 1'b1, 3'b100, 2'd0, 16'd2);
      chk("neg1_ready", 32'(req_ready), 32'h2);
      step();
      req_valid = 4'b0000;
      #1;
      chk_res("neg1", 1'b1, 3'b111, 2'd1, 16'd3);
      step();
      chk_res("drain", 1'b0, 3'b111, 2'd1, 16'd3);

      // requester 3 alone brings rr_ptr back to 0: -2 + 1 = -1
      req_valid = 4'b1000;
      req_a[7:6] = 2'b10;
      req_b[7:6] = 2'b01;
      step();
      req_valid = 4'b0000;
      #1;
      chk_res("r3", 1'b1, 3'b111, 2'd3, 16'd4);
      step();

      // round robin with everyone valid
      req_a = {2'b10, 2'b01, 2'b11, 2'b01};
      req_b = {2'b01, 2'b01, 2'b11, 2'b00};
      rr_exp[0] = 3'b001;
      rr_exp[1] = 3'b110;
      rr_exp[2] = 3'b010;
      rr_exp[3] = 3'b111;
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
         step();
         chk_res("rr", 1'b1, rr_exp[i % 4], 2'(i % 4), 16'(5 + i));
      end

      // backpressure: held result stable, no grants
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", 32'(req_ready), 32'h0);
         step();
         chk_res("bp", 1'b1, 3'b111, 2'd3, 16'd12);
      end
      res_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'h1);
      step();
      chk_res("bp_refill", 1'b1, 3'b001, 2'd0, 16'd13);
      chk("sat_mid", 32'(op_count_s), 32'd13);

      // single requester granted every cycle; saturating counter
      req_valid = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("solo_ready", 32'(req_ready), 32'h1);
         step();
      end
      chk_res("solo", 1'b1, 3'b001, 2'd0, 16'd33);
      chk("sat_count", 32'(op_count_s), 32'd15);
      step();
      chk("sat_hold", 32'(op_count_s), 32'd15);

      // reset mid-transaction with a held result
      res_ready = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      chk_res("midrst", 1'b0, 3'd0, 2'd0, 16'd0);
      chk("midrst_ready", 32'(req_ready), 32'h0);
      chk("midrst_sat", 32'(op_count_s), 32'd0);
      req_valid = 4'b0000;
      res_ready = 1'b1;
      step();
      rst = 1'b1;
      step();
      step();
      chk_res("post_rst", 1'b0, 3'd0, 2'd0, 16'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
